// File: rtl/conv_pad_sched_pkg.sv
// rtl/conv_pad_sched_pkg.sv - shared state encoding and sizing constants for the padding scheduler
package conv_pad_sched_pkg;

    localparam int MAX_SIZE_DEF = 64;
    localparam int CNT_W        = 13;
    localparam int IDLE_W       = 16;
    localparam int TMO_MULT     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_t;

endpackage

// File: rtl/conv_pad_sched_pad_pipe_reg.sv
// rtl/conv_pad_sched_pad_pipe_reg.sv - one-cycle register stage feeding the padding datapath
module pad_pipe_reg #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     pad_valid,
    output logic signed [DATA_W-1:0] pad_data
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pad_valid <= 1'b0;
            pad_data  <= '0;
        end else begin
            pad_valid <= in_valid;
            if (in_valid) begin
                pad_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/conv_pad_sched.sv
// rtl/conv_pad_sched.sv - frame scheduler streaming N*N pixels into a padding datapath and counting its (N+2)^2 outputs
module conv_pad_sched
    import conv_pad_sched_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_SIZE = MAX_SIZE_DEF,
    parameter int SZ_W     = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SZ_W-1:0]          cfg_size,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     src_valid,
    input  logic signed [DATA_W-1:0] src_data,
    output logic                     src_ready,
    output logic                     pad_valid,
    output logic signed [DATA_W-1:0] pad_data,
    output logic [SZ_W-1:0]          pad_size,
    output logic                     pad_clr,
    input  logic                     pad_o_valid,
    output logic [CNT_W-1:0]         out_cnt
);

    state_t state, state_nxt;

    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  nn;
    logic [CNT_W-1:0]  nn2;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] tmo;
    logic [CNT_W-1:0]  n_ext;
    logic [CNT_W-1:0]  n2_ext;

    logic size_ok;
    logic accept;
    logic last_acc;
    logic out_full;
    logic cnt_out;
    logic timeout;
    logic err_c;

    assign size_ok   = (cfg_size != '0) && (int'(cfg_size) <= MAX_SIZE);
    assign src_ready = (state == S_STREAM);
    assign accept    = src_valid && src_ready;
    assign last_acc  = accept && (in_cnt == nn - CNT_W'(1));
    assign out_full  = (out_cnt == nn2);
    assign n_ext     = CNT_W'(pad_size);
    assign n2_ext    = n_ext + CNT_W'(2);

    // Once the full padded frame is counted, further strobes are stragglers and must not count.
    assign cnt_out = pad_o_valid &&
                     ((state == S_STREAM) || ((state == S_DRAIN) && !out_full));
    assign timeout = (state == S_DRAIN) && !out_full && !pad_o_valid && (idle_cnt >= tmo);

    always_comb begin
        state_nxt = state;
        err_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        state_nxt = S_CLEAR;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            S_CLEAR:  state_nxt = S_STREAM;
            S_STREAM: begin
                if (last_acc) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_full) begin
                    state_nxt = S_FIN;
                end else if (timeout) begin
                    err_c     = 1'b1;
                    state_nxt = S_FIN;
                end
            end
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Pulses are gated by reset so an abandoned frame never reports completion or failure.
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FIN) && rst;
    assign err     = err_c && rst;
    assign pad_clr = (state == S_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            pad_size <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            nn       <= '0;
            nn2      <= '0;
            idle_cnt <= '0;
            tmo      <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && start && size_ok) begin
                pad_size <= cfg_size;
            end
            if (state == S_CLEAR) begin
                nn       <= n_ext * n_ext;
                nn2      <= n2_ext * n2_ext;
                tmo      <= IDLE_W'(TMO_MULT) * IDLE_W'(n2_ext);
                in_cnt   <= '0;
                out_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                if (accept) begin
                    in_cnt <= in_cnt + CNT_W'(1);
                end
                if (cnt_out) begin
                    out_cnt <= out_cnt + CNT_W'(1);
                end
                if (state == S_DRAIN) begin
                    idle_cnt <= pad_o_valid ? '0 : idle_cnt + IDLE_W'(1);
                end
            end
        end
    end

    pad_pipe_reg #(
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (src_data),
        .pad_valid (pad_valid),
        .pad_data  (pad_data)
    );

endmodule
